// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the fetch PC controller: FSM encodings, default vectors
// and the branch-kind decode used by both the target generator and ALU-control decode.
package pc_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        BK_NONE   = 2'd0,
        BK_BRANCH = 2'd1,
        BK_JAL    = 2'd2,
        BK_JALR   = 2'd3
    } branch_kind_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0100;
    localparam logic [31:0] FETCH_STRIDE     = 32'd4;

    // JALR outranks JAL, which outranks a conditional branch.
    function automatic branch_kind_e decode_kind(input logic branch,
                                                 input logic jal,
                                                 input logic jalr);
        branch_kind_e kind;
        if (jalr) begin
            kind = BK_JALR;
        end else if (jal) begin
            kind = BK_JAL;
        end else if (branch) begin
            kind = BK_BRANCH;
        end else begin
            kind = BK_NONE;
        end
        return kind;
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_branch_target_gen.sv
// Resolves whether the execute-stage instruction redirects fetch, and where to.
// A misaligned destination is replaced by the trap vector.
module branch_target_gen
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEFAULT
) (
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic        ex_jal,
    input  logic        ex_jalr,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic        alu_cmp,
    input  logic [31:0] alu_q,
    output logic        take,
    output logic        misalign,
    output logic [31:0] target
);

    branch_kind_e kind_s;
    logic [31:0]  raw_target_s;

    // Select the redirect destination and qualify it with validity and alignment.
    always_comb begin
        kind_s       = decode_kind(ex_branch, ex_jal, ex_jalr);
        raw_target_s = ex_pc + ex_imm;
        take         = 1'b0;
        case (kind_s)
            BK_JALR: begin
                raw_target_s = {alu_q[31:1], 1'b0};
                take         = ex_valid;
            end
            BK_JAL:    take = ex_valid;
            BK_BRANCH: take = ex_valid & alu_cmp;
            default:   take = 1'b0;
        endcase
        misalign = take & is_misaligned(raw_target_s);
        if (misalign) begin
            target = TRAP_VEC;
        end else begin
            target = raw_target_s;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-side PC controller: sequential fetch over a req/ack handshake, redirect on
// resolved control flow, and suppression of a fetch that a redirect made stale.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic        ex_jal,
    input  logic        ex_jalr,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic        alu_cmp,
    input  logic [31:0] alu_q,
    input  logic        imem_ack,
    input  logic        if_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic        redirect,
    output logic        misalign_trap
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic         req_q, req_d;
    logic         valid_q, valid_d;
    logic         kill_q, kill_d;
    logic         take_s;
    logic         misalign_s;
    logic [31:0]  target_s;

    branch_target_gen #(.TRAP_VEC(TRAP_VEC)) u_btg (
        .ex_valid (ex_valid),
        .ex_branch(ex_branch),
        .ex_jal   (ex_jal),
        .ex_jalr  (ex_jalr),
        .ex_pc    (ex_pc),
        .ex_imm   (ex_imm),
        .alu_cmp  (alu_cmp),
        .alu_q    (alu_q),
        .take     (take_s),
        .misalign (misalign_s),
        .target   (target_s)
    );

    // Next-state logic: a redirect overrides normal sequencing in every state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        if_pc_d = if_pc_q;
        req_d   = req_q;
        valid_d = valid_q;
        kill_d  = kill_q;
        if (take_s) begin
            pc_d    = target_s;
            valid_d = 1'b0;
            // An unanswered request must keep its address; its data is discarded later.
            if ((state_q == ST_REQ) && !imem_ack) begin
                kill_d = 1'b1;
            end else begin
                state_d = ST_REQ;
                req_d   = 1'b1;
                addr_d  = target_s;
                kill_d  = 1'b0;
            end
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
                ST_REQ: begin
                    if (imem_ack && kill_q) begin
                        kill_d  = 1'b0;
                        addr_d  = pc_q;
                        valid_d = 1'b0;
                    end else if (imem_ack) begin
                        valid_d = 1'b1;
                        if_pc_d = addr_q;
                        pc_d    = pc_q + FETCH_STRIDE;
                        addr_d  = pc_q + FETCH_STRIDE;
                        if (if_ready) begin
                            state_d = ST_REQ;
                        end else begin
                            state_d = ST_HOLD;
                            req_d   = 1'b0;
                        end
                    end else begin
                        valid_d = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (if_ready) begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        valid_d = 1'b0;
                    end else begin
                        valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_BOOT;
                    req_d   = 1'b0;
                    valid_d = 1'b0;
                    kill_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            if_pc_q <= 32'h0000_0000;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            if_pc_q <= if_pc_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            kill_q  <= kill_d;
        end
    end

    assign imem_req      = req_q;
    assign imem_addr     = addr_q;
    assign if_valid      = valid_q;
    assign if_pc         = if_pc_q;
    assign redirect      = take_s & ~rst;
    assign misalign_trap = misalign_s & ~rst;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a transaction-level reference model
// checked on every falling edge, plus literal expectations at key points.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_branch, ex_jal, ex_jalr, alu_cmp, imem_ack, if_ready;
    logic [31:0] ex_pc, ex_imm, alu_q;
    logic        imem_req, if_valid, redirect, misalign_trap;
    logic [31:0] imem_addr, if_pc;

    int checks = 0;
    int errors = 0;

    // Reference model: next fetch PC, the outstanding request, and the word shown to decode.
    logic        m_boot;
    logic [31:0] m_fetch_pc;
    logic        m_req;
    logic [31:0] m_req_addr;
    logic        m_stale;
    logic        m_out_valid;
    logic [31:0] m_out_pc;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_branch    (ex_branch),
        .ex_jal       (ex_jal),
        .ex_jalr      (ex_jalr),
        .ex_pc        (ex_pc),
        .ex_imm       (ex_imm),
        .alu_cmp      (alu_cmp),
        .alu_q        (alu_q),
        .imem_ack     (imem_ack),
        .if_ready     (if_ready),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .redirect     (redirect),
        .misalign_trap(misalign_trap)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_eval(output logic tk, output logic mis, output logic [31:0] dest);
        tk   = 1'b0;
        mis  = 1'b0;
        dest = 32'h0;
        if (!rst && ex_valid) begin
            if (ex_jalr) begin
                tk = 1'b1; dest = alu_q & 32'hFFFF_FFFE;
            end else if (ex_jal) begin
                tk = 1'b1; dest = ex_pc + ex_imm;
            end else if (ex_branch && alu_cmp) begin
                tk = 1'b1; dest = ex_pc + ex_imm;
            end
        end
        if (tk && (dest % 32'd4) != 32'd0) begin
            mis  = 1'b1;
            dest = 32'h0000_0100;
        end
    endtask

    task automatic model_reset();
        m_boot      = 1'b1;
        m_fetch_pc  = 32'h0;
        m_req       = 1'b0;
        m_req_addr  = 32'h0;
        m_stale     = 1'b0;
        m_out_valid = 1'b0;
        m_out_pc    = 32'h0;
    endtask

    task automatic model_edge();
        logic tk, mis;
        logic [31:0] dest;
        model_eval(tk, mis, dest);
        if (rst) begin
            model_reset();
        end else if (tk) begin
            m_fetch_pc  = dest;
            m_out_valid = 1'b0;
            m_boot      = 1'b0;
            if (m_req && !imem_ack) begin
                m_stale = 1'b1;
            end else begin
                m_req = 1'b1; m_req_addr = dest; m_stale = 1'b0;
            end
        end else if (m_boot) begin
            m_boot = 1'b0; m_req = 1'b1; m_req_addr = m_fetch_pc;
        end else if (m_req) begin
            if (imem_ack && m_stale) begin
                m_stale = 1'b0; m_req_addr = m_fetch_pc; m_out_valid = 1'b0;
            end else if (imem_ack) begin
                m_out_valid = 1'b1;
                m_out_pc    = m_req_addr;
                m_fetch_pc  = m_fetch_pc + 32'd4;
                m_req_addr  = m_fetch_pc;
                m_req       = if_ready;
            end else begin
                m_out_valid = 1'b0;
            end
        end else if (if_ready) begin
            m_out_valid = 1'b0; m_req = 1'b1; m_req_addr = m_fetch_pc;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_ex();
        ex_valid = 1'b0; ex_branch = 1'b0; ex_jal = 1'b0; ex_jalr = 1'b0;
        alu_cmp = 1'b0; ex_pc = 32'h0; ex_imm = 32'h0; alu_q = 32'h0;
    endtask

    // Per-cycle comparison of every meaningful DUT output against the model.
    always @(negedge clk) begin : cmp_blk
        logic tk, mis;
        logic [31:0] dest;
        model_eval(tk, mis, dest);
        chk("imem_req", {31'h0, imem_req}, {31'h0, m_req});
        if (m_req) chk("imem_addr", imem_addr, m_req_addr);
        chk("if_valid", {31'h0, if_valid}, {31'h0, m_out_valid});
        if (m_out_valid) chk("if_pc", if_pc, m_out_pc);
        chk("redirect", {31'h0, redirect}, {31'h0, tk});
        chk("misalign_trap", {31'h0, misalign_trap}, {31'h0, mis});
    end

    initial begin
        rst = 1'b1; imem_ack = 1'b0; if_ready = 1'b0;
        clear_ex();
        model_reset();
        #1;
        chk("reset_req", {31'h0, imem_req}, 32'h0);
        chk("reset_valid", {31'h0, if_valid}, 32'h0);
        step(); step();
        rst = 1'b0;

        // Sequential fetch, ack every cycle.
        imem_ack = 1'b1; if_ready = 1'b1;
        step(); chk("t1_addr0", imem_addr, 32'h0); chk("t1_req", {31'h0, imem_req}, 32'h1);
        step(); chk("t1_addr4", imem_addr, 32'h4); chk("t1_pc0", if_pc, 32'h0);
        step(); chk("t1_addr8", imem_addr, 32'h8); chk("t1_pc4", if_pc, 32'h4);
        step(); chk("t1_addrC", imem_addr, 32'hC); chk("t1_pc8", if_pc, 32'h8);

        // Taken branch coinciding with an ack.
        ex_valid = 1'b1; ex_branch = 1'b1; alu_cmp = 1'b1; ex_pc = 32'h40; ex_imm = 32'h20;
        #1 chk("t2_redirect", {31'h0, redirect}, 32'h1);
        step(); clear_ex();
        chk("t2_addr", imem_addr, 32'h60); chk("t2_valid", {31'h0, if_valid}, 32'h0);

        // Redirects while the request waits; the late ack is dropped.
        imem_ack = 1'b0;
        step();
        ex_valid = 1'b1; ex_jal = 1'b1; ex_pc = 32'h200; ex_imm = 32'h10;
        step(); clear_ex();
        chk("t3_addr_stable", imem_addr, 32'h60);
        step();
        ex_valid = 1'b1; ex_branch = 1'b1; alu_cmp = 1'b1; ex_pc = 32'h2F0; ex_imm = 32'h10;
        step(); clear_ex();
        chk("t3_addr_stable2", imem_addr, 32'h60);
        step();
        imem_ack = 1'b1;
        step();
        chk("t3_dropped", {31'h0, if_valid}, 32'h0); chk("t3_newaddr", imem_addr, 32'h300);

        // Misaligned JALR target traps.
        ex_valid = 1'b1; ex_jalr = 1'b1; alu_q = 32'h0000_1003;
        #1 chk("t4_trap", {31'h0, misalign_trap}, 32'h1);
        step(); clear_ex();
        chk("t4_addr", imem_addr, 32'h100);

        // Decode back-pressure holds the fetched word.
        if_ready = 1'b0;
        step(); imem_ack = 1'b0;
        chk("t5_valid", {31'h0, if_valid}, 32'h1); chk("t5_pc", if_pc, 32'h100);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_hold_pc", if_pc, 32'h100); chk("t5_hold_req", {31'h0, imem_req}, 32'h0);
        end
        if_ready = 1'b1;
        step(); chk("t5_resume", imem_addr, 32'h104);
        imem_ack = 1'b1;
        step(); chk("t5_pc2", if_pc, 32'h104);
        if_ready = 1'b0;
        step(); imem_ack = 1'b0;
        ex_valid = 1'b1; ex_jal = 1'b1; ex_pc = 32'h500; ex_imm = 32'h8;
        step(); clear_ex();
        chk("t5_hold_take", imem_addr, 32'h508); chk("t5_hold_take_v", {31'h0, if_valid}, 32'h0);

        // PC wrap and reset mid-request.
        imem_ack = 1'b1; if_ready = 1'b1;
        ex_valid = 1'b1; ex_jal = 1'b1; ex_pc = 32'hFFFF_FFF0; ex_imm = 32'h0000_000C;
        step(); clear_ex();
        chk("t6_top", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("t6_pc", if_pc, 32'hFFFF_FFFC); chk("t6_wrap", imem_addr, 32'h0);
        rst = 1'b1; model_reset();
        #1;
        chk("t6_rst_req", {31'h0, imem_req}, 32'h0); chk("t6_rst_valid", {31'h0, if_valid}, 32'h0);
        step(); step();
        rst = 1'b0;
        step(); chk("t6_boot_addr", imem_addr, 32'h0);
        step(); chk("t6_boot_pc", if_pc, 32'h0); chk("t6_boot_next", imem_addr, 32'h4);
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
